eight_reg_bank_16bit: RTL

//   Write-side counterpart of the 8:1 16-bit output mux. A 1-to-8 demux steers D

---
 rtl/eight_reg_bank_16bit.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/eight_reg_bank_16bit.sv
// rtl/eight_reg_bank_16bit.sv - eight-entry 16-bit register bank with demux write and sequenced clear
//
// Purpose:
//   Write side of the 8:1 output mux. A 1-to-8 demux steers D into one of
//   eight registers chosen by {S2,S1,S0}. All eight registers appear in
//   parallel on Q0..Q7. A clear engine zeroes the bank one register per
//   cycle, Q0 first, and reports progress on Busy.
//
// Ports:
//   Clk      in   1      rising-edge clock
//   Reset_n  in   1      asynchronous active-low reset
//   D        in   WIDTH  write data
//   S0/S1/S2 in   1      write select, S2 is the MSB
//   Enable   in   1      demux enable
//   Write    in   1      write strobe
//   Clear    in   1      start a clear sweep
//   Busy     out  1      high while the sweep runs (8 cycles)
//   Ack      out  1      one-cycle pulse after each accepted write
//   Q0..Q7   out  WIDTH  register contents

module eight_reg_bank_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] D,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             Enable,
  input  logic             Write,
  input  logic             Clear,
  output logic             Busy,
  output logic             Ack,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [2:0]       r_cnt;
  logic             r_ack;
  logic [WIDTH-1:0] r_q [8];

  logic [2:0]       w_sel;
  logic             w_start;
  logic             w_sweep_en;
  logic             w_wr_accept;

  assign w_sel = {S2, S1, S0};

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and control decode. Clear has priority over a write in IDLE,
  // and writes are never accepted during the sweep.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_sweep_en   = 1'b0;
    w_wr_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Clear) begin
          w_next_state = ST_SWEEP;
          w_start      = 1'b1;
        end else if (Write && Enable) begin
          w_wr_accept  = 1'b1;
        end
      end
      ST_SWEEP: begin
        w_sweep_en = 1'b1;
        // The edge that clears Q7 is also the one where the counter wraps,
        // so leaving here needs no separate terminal state.
        if (r_cnt == 3'd7) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Sweep counter: points at the register cleared on the next edge
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_cnt <= 3'd0;
    end else if (w_start) begin
      r_cnt <= 3'd0;
    end else if (w_sweep_en) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  // Register bank. Sweep clear and write are mutually exclusive by state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 8; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_sweep_en && (r_cnt == 3'(i))) begin
          r_q[i] <= '0;
        end else if (w_wr_accept && (w_sel == 3'(i))) begin
          r_q[i] <= D;
        end
      end
    end
  end

  // Ack follows each accepted write by one cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_ack <= 1'b0;
    end else begin
      r_ack <= w_wr_accept;
    end
  end

  assign Busy = (r_state == ST_SWEEP);
  assign Ack  = r_ack;

  assign Q0 = r_q[0];
  assign Q1 = r_q[1];
  assign Q2 = r_q[2];
  assign Q3 = r_q[3];
  assign Q4 = r_q[4];
  assign Q5 = r_q[5];
  assign Q6 = r_q[6];
  assign Q7 = r_q[7];

endmodule
